// File: rtl/lb_window_reader.sv
// lb_window_reader: walks a full line buffer, fetching WIN-wide entry triplets
// one start address at a time and handing each to a valid/ready consumer.
// A read that never answers is reissued after TIMEOUT waiting cycles.
module lb_window_reader #(
  parameter int LINE_W  = 28,
  parameter int WIN     = 3,
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lb_full,
  output logic        lb_rd_en,
  output logic [6:0]  lb_rd_addr,
  input  logic [23:0] lb_rd_data,
  input  logic        lb_data_valid,
  output logic [23:0] win_data,
  output logic        win_valid,
  input  logic        win_ready,
  output logic        line_done,
  output logic        retry,
  output logic        busy
);

  localparam int LAST  = LINE_W - WIN;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    OUT,
    DONE
  } state_t;

  state_t             state, state_nxt;
  logic [6:0]         addr, addr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               capture;

  // State register; reset abandons any line in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic plus the one-cycle strobes (read request, retry, done).
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    lb_rd_en  = 1'b0;
    retry     = 1'b0;
    line_done = 1'b0;
    case (state)
      IDLE: begin
        if (lb_full) begin
          addr_nxt  = '0;
          state_nxt = REQ;
        end
      end
      REQ: begin
        lb_rd_en  = 1'b1;
        cnt_nxt   = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        // Returning data beats the timeout when both land on the same cycle.
        if (lb_data_valid) begin
          capture   = 1'b1;
          state_nxt = OUT;
        end else if (cnt >= CNT_W'(TIMEOUT - 1)) begin
          retry     = 1'b1;
          cnt_nxt   = CNT_W'(TIMEOUT);
          state_nxt = REQ;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      OUT: begin
        if (win_ready) begin
          if (addr < 7'(LAST)) begin
            addr_nxt  = addr + 1'b1;
            state_nxt = REQ;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        line_done = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Address, timeout counter and captured window registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      cnt      <= '0;
      win_data <= '0;
    end else begin
      addr <= addr_nxt;
      cnt  <= cnt_nxt;
      if (capture) begin
        win_data <= lb_rd_data;
      end
    end
  end

  assign lb_rd_addr = addr;
  assign win_valid  = (state == OUT);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_lb_window_reader.sv
// Directed bench for lb_window_reader with a one-cycle line-buffer model and
// a scoreboard of expected {address, window} pairs.
module tb_lb_window_reader;

  localparam int LINE_W  = 28;
  localparam int WIN     = 3;
  localparam int TIMEOUT = 8;
  localparam int NWIN    = LINE_W - WIN + 1;

  logic        clk;
  logic        rst;
  logic        lb_full;
  logic        lb_rd_en;
  logic [6:0]  lb_rd_addr;
  logic [23:0] lb_rd_data;
  logic        lb_data_valid;
  logic [23:0] win_data;
  logic        win_valid;
  logic        win_ready;
  logic        line_done;
  logic        retry;
  logic        busy;

  lb_window_reader #(.LINE_W(LINE_W), .WIN(WIN), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .lb_full      (lb_full),
    .lb_rd_en     (lb_rd_en),
    .lb_rd_addr   (lb_rd_addr),
    .lb_rd_data   (lb_rd_data),
    .lb_data_valid(lb_data_valid),
    .win_data     (win_data),
    .win_valid    (win_valid),
    .win_ready    (win_ready),
    .line_done    (line_done),
    .retry        (retry),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  addr;
    logic [23:0] data;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int line_acc = 0;
  int rd_cnt   = 0;
  int retry_cnt = 0;
  int done_cnt = 0;
  int cyc      = 0;
  int last_req = 0;

  // buffer model controls
  int drop_addr = -1;
  int drop_left = 0;
  int slow_addr = -1;
  int slow_left = 0;
  bit spurious  = 1'b0;
  int pend_cnt  = 0;
  int paddr     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_line();
    exp_t e;
    for (int a = 0; a < NWIN; a++) begin
      e.addr = 7'(a);
      e.data = {8'(a + 2), 8'(a + 1), 8'(a)};
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_full();
    @(posedge clk); #1;
    lb_full = 1'b1;
    @(posedge clk); #1;
    lb_full = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start;
    start = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_cnt != start) break;
    end
    chk("line_done_seen", done_cnt - start, 1);
  endtask

  // Line buffer model: answers a request one cycle later with entry[i]=i,
  // optionally dropping or delaying one address, or injecting junk data.
  always @(posedge clk) begin
    #2;
    lb_data_valid = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        lb_data_valid = 1'b1;
        lb_rd_data    = {8'(paddr + 2), 8'(paddr + 1), 8'(paddr)};
      end
    end
    if (spurious) begin
      lb_data_valid = 1'b1;
      lb_rd_data    = 24'hDEADBE;
    end
    if (lb_rd_en) begin
      if (drop_left > 0 && int'(lb_rd_addr) == drop_addr) begin
        drop_left--;
      end else begin
        paddr = int'(lb_rd_addr);
        if (slow_left > 0 && int'(lb_rd_addr) == slow_addr) begin
          slow_left--;
          pend_cnt = TIMEOUT;
        end else begin
          pend_cnt = 1;
        end
      end
    end
  end

  // Monitor: scoreboard compare on each accepted window, request address
  // order, retry timing and per-line window count.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      line_acc = 0;
    end else begin
      if (win_valid) chk("no_read_in_out", lb_rd_en, 0);
      if (win_valid && win_ready) begin
        n_acc++;
        line_acc++;
        n_checks++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_window: observed %0h expected none", win_data);
        end
        if (exp_q.size() != 0) begin
          chk("win_data", win_data, exp_q[0].data);
          void'(exp_q.pop_front());
        end
      end
      if (lb_rd_en) begin
        rd_cnt++;
        last_req = cyc;
        if (exp_q.size() != 0) chk("rd_addr", lb_rd_addr, exp_q[0].addr);
      end
      if (retry) begin
        retry_cnt++;
        chk("retry_latency", cyc - last_req, TIMEOUT);
        if (exp_q.size() != 0) chk("retry_addr", lb_rd_addr, exp_q[0].addr);
      end
      if (line_done) begin
        done_cnt++;
        chk("windows_per_line", line_acc, NWIN);
        line_acc = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, r0, d0, rd0;
    rst       = 1'b1;
    lb_full   = 1'b0;
    win_ready = 1'b1;
    lb_rd_data    = '0;
    lb_data_valid = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_rd_en", lb_rd_en, 0);
    chk("rst_rd_addr", lb_rd_addr, 0);
    chk("rst_win_data", win_data, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_line_done", line_done, 0);
    chk("rst_retry", retry, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // full line, no backpressure
    acc0 = n_acc; r0 = retry_cnt;
    push_line();
    pulse_full();
    wait_done(400);
    chk("full_accepted", n_acc - acc0, NWIN);
    chk("full_busy_after", busy, 0);
    chk("full_no_retry", retry_cnt - r0, 0);
    chk("full_queue_empty", exp_q.size(), 0);

    // backpressure at addr 3, with junk valid pulses that must be ignored
    push_line();
    pulse_full();
    for (int i = 0; i < 200; i++) begin
      if (win_valid && lb_rd_addr == 7'd3) break;
      @(posedge clk); #1;
    end
    win_ready = 1'b0;
    spurious  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_win_data", win_data, 24'h050403);
      chk("bp_win_valid", win_valid, 1);
      chk("bp_rd_en", lb_rd_en, 0);
    end
    @(posedge clk); #1;
    win_ready = 1'b1;
    spurious  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_rd_en", lb_rd_en, 1);
    chk("bp_next_addr", lb_rd_addr, 4);
    wait_done(400);

    // dropped read at addr 7
    acc0 = n_acc; r0 = retry_cnt;
    drop_addr = 7; drop_left = 1;
    push_line();
    pulse_full();
    wait_done(600);
    chk("drop_retry_count", retry_cnt - r0, 1);
    chk("drop_accepted", n_acc - acc0, NWIN);

    // data arriving on the timeout cycle wins over retry
    acc0 = n_acc; r0 = retry_cnt;
    slow_addr = 5; slow_left = 1;
    push_line();
    pulse_full();
    wait_done(600);
    chk("slow_no_retry", retry_cnt - r0, 0);
    chk("slow_accepted", n_acc - acc0, NWIN);

    // reset while waiting on addr 10
    d0 = done_cnt;
    push_line();
    pulse_full();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (lb_rd_en && lb_rd_addr == 7'd10) break;
    end
    @(posedge clk); #1;
    chk("pre_rst_win_data", win_data, 24'h0B0A09);
    rst = 1'b1;
    #1;
    chk("mid_rst_rd_en", lb_rd_en, 0);
    chk("mid_rst_rd_addr", lb_rd_addr, 0);
    chk("mid_rst_win_data", win_data, 0);
    chk("mid_rst_win_valid", win_valid, 0);
    chk("mid_rst_line_done", line_done, 0);
    chk("mid_rst_retry", retry, 0);
    chk("mid_rst_busy", busy, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rd0 = rd_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_no_reads", rd_cnt - rd0, 0);
    chk("idle_no_done", done_cnt - d0, 0);
    chk("idle_busy", busy, 0);
    acc0 = n_acc;
    push_line();
    pulse_full();
    wait_done(400);
    chk("restart_accepted", n_acc - acc0, NWIN);

    // lb_full held high through DONE
    push_line();
    push_line();
    @(posedge clk); #1;
    lb_full = 1'b1;
    wait_done(400);
    chk("held_busy_after_done", busy, 0);
    @(negedge clk);
    chk("held_idle_rd_en", lb_rd_en, 0);
    @(negedge clk);
    chk("held_restart_rd_en", lb_rd_en, 1);
    chk("held_restart_addr", lb_rd_addr, 0);
    lb_full = 1'b0;
    wait_done(400);
    chk("held_queue_empty", exp_q.size(), 0);
    chk("held_busy_end", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
